custom_ff_unit: RTL and testbench
=================================

// Module: custom_ff_unit
// PURPOSE
//   Multi-mode storage register: plain D flip-flop, parallel load, or left shift.
//   Synchronous parallel load from d_load; shift left with serial-in from d.
//   Otherwise captures d every cycle.
//   Small utility cell used in datapaths needing a loadable/shiftable register.
// PARAMETERS
//   WIDTH      4     register / data width in bits (>=2)
//   RESET_VAL  '0    value forced onto q while reset is asserted
// PORTS
//   clk       in   1      single clock; all state updates on rising edge
//   rst       in   1      reset, asynchronous, active-low (0 = reset)
//   load_en   in   1      parallel-load enable
//   shift_en  in   1      shift enable
//   d_load    in   WIDTH  parallel-load data
//   d         in   WIDTH  capture data; d[0] is the serial-in bit when shifting
//   q         out  WIDTH  registered output
// BEHAVIOUR
//   - One clock, one reset: asynchronous, active-low.
//   - rst=0 -> q=RESET_VAL immediately, without waiting for a clock edge.
//   - rst=0 overrides all other inputs. Release is synchronous to the next
//     rising clk edge (no update on the release edge itself is not required).
//   - Per rising clk edge, with rst=1, exactly one action by priority:
//       1. load_en=1               : q <= d_load
//       2. load_en=0, shift_en=1   : q <= {q[WIDTH-2:0], d[0]}  (MSB discarded)
//       3. load_en=0, shift_en=0   : q <= d                     (plain D-FF)
//   - load_en and shift_en both 1: load wins; no shift that cycle.
//   - Latency: 1 cycle from sampled inputs to q. No combinational input->q path.
//   - Continuous shift_en: after WIDTH shifts, q equals the last WIDTH d[0] bits,
//     oldest in the MSB.
//   - No X propagation from unused d[WIDTH-1:1] while shifting; those bits are ignored.
//   - Reset asserted mid-shift or mid-load: q goes to RESET_VAL at once.
//     No pending operation survives reset.
//   - Only q is a state element; there is no FSM and no handshake.
// TESTING
//   1. rst=0 with d=4'hF, load_en=1 toggling, clk running -> q stays 4'h0.
//      Assert rst=0 asynchronously mid-cycle -> q=0 before the next edge.
//   2. rst=1, load_en=1, d_load=4'hA for one edge -> q=4'hA after that edge.
//   3. From q=4'hA: shift_en=1, d=4'h0 for 4 edges -> q = 4'h4, 4'h8, 4'h0, 4'h0.
//      With d[0]=1 instead: 4'h5, 4'hB, 4'h7, 4'hF.
//   4. load_en=1, shift_en=1, d_load=4'h3, q=4'hC -> q=4'h3 (load priority).
//   5. load_en=0, shift_en=0, d=4'h6 -> q=4'h6 next edge.
//      Change d to 4'h9 mid-cycle -> q unchanged until the following edge.
//   6. After q=4'hA, pulse rst=0 between edges -> q=4'h0 immediately.
//      Release rst -> normal operation resumes on the next edge.

Source files
------------

// File: rtl/custom_ff_unit.sv
// Multi-mode storage register: parallel load, left shift with serial-in from d[0],
// or plain D capture. Load has priority over shift; reset is asynchronous, active-low.
module custom_ff_unit #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d_load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_next;

  // Only d[0] feeds the shift path, so d[WIDTH-1:1] cannot leak X while shifting.
  always_comb begin
    q_next = d;
    if (load_en) begin
      q_next = d_load;
    end else if (shift_en) begin
      q_next = {q[WIDTH-2:0], d[0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: tb/tb_custom_ff_unit.sv
// Directed-vector bench for custom_ff_unit: reset, load, shift, priority,
// plain capture and mid-cycle reset, each with hand-computed expectations.
module tb_custom_ff_unit;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         load_en;
  logic         shift_en;
  logic [W-1:0] d_load;
  logic [W-1:0] d;
  logic [W-1:0] q;

  int n_vec;
  int n_err;
  logic [W-1:0] exp_q[$];

  custom_ff_unit #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .shift_en (shift_en),
    .d_load   (d_load),
    .d        (d),
    .q        (q)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic le, input logic se, input logic [W-1:0] dl,
                       input logic [W-1:0] dd);
    load_en  = le;
    shift_en = se;
    d_load   = dl;
    d        = dd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 1'b0, 4'hF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      load_en = ~load_en;
      tick();
      n_vec++;
      if (q !== 4'h0) begin
        $display("FAIL reset_hold[%0d]: q=%h expected=%h", i, q, 4'h0);
        n_err++;
      end
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 4'hF);
    tick();
    n_vec++;
    if (q !== 4'hF) begin
      $display("FAIL reset_release_capture: q=%h expected=%h", q, 4'hF);
      n_err++;
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (q !== 4'h0) begin
      $display("FAIL reset_async: q=%h expected=%h", q, 4'h0);
      n_err++;
    end
    rst = 1'b1;
  endtask

  task automatic test_load();
    drive(1'b1, 1'b0, 4'hA, 4'h5);
    tick();
    n_vec++;
    if (q !== 4'hA) begin
      $display("FAIL load: q=%h expected=%h", q, 4'hA);
      n_err++;
    end
  endtask

  task automatic test_shift(input logic [W-1:0] din);
    logic [W-1:0] exp_v;
    drive(1'b1, 1'b0, 4'hA, 4'h0);
    tick();
    drive(1'b0, 1'b1, 4'h0, din);
    for (int i = 0; i < W; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (q !== exp_v) begin
        $display("FAIL shift_d%h[%0d]: q=%h expected=%h", din, i, q, exp_v);
        n_err++;
      end
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b0, 4'hC, 4'h0);
    tick();
    drive(1'b1, 1'b1, 4'h3, 4'hF);
    tick();
    n_vec++;
    if (q !== 4'h3) begin
      $display("FAIL load_priority: q=%h expected=%h", q, 4'h3);
      n_err++;
    end
  endtask

  task automatic test_capture();
    drive(1'b0, 1'b0, 4'hF, 4'h6);
    tick();
    n_vec++;
    if (q !== 4'h6) begin
      $display("FAIL capture: q=%h expected=%h", q, 4'h6);
      n_err++;
    end
    #2 d = 4'h9;
    #1;
    n_vec++;
    if (q !== 4'h6) begin
      $display("FAIL capture_hold: q=%h expected=%h", q, 4'h6);
      n_err++;
    end
    tick();
    n_vec++;
    if (q !== 4'h9) begin
      $display("FAIL capture_next: q=%h expected=%h", q, 4'h9);
      n_err++;
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 4'hA, 4'h0);
    tick();
    drive(1'b0, 1'b1, 4'h0, 4'h1);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (q !== 4'h0) begin
      $display("FAIL reset_mid: q=%h expected=%h", q, 4'h0);
      n_err++;
    end
    tick();
    n_vec++;
    if (q !== 4'h0) begin
      $display("FAIL reset_mid_edge: q=%h expected=%h", q, 4'h0);
      n_err++;
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'hF, 4'h5);
    tick();
    n_vec++;
    if (q !== 4'h5) begin
      $display("FAIL reset_resume: q=%h expected=%h", q, 4'h5);
      n_err++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    #2;
    test_reset();
    test_load();
    exp_q = '{4'h4, 4'h8, 4'h0, 4'h0};
    test_shift(4'h0);
    exp_q = '{4'h5, 4'hB, 4'h7, 4'hF};
    test_shift(4'hB);
    test_priority();
    test_capture();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
